qpp_deinterleaver: RTL and testbench

- Inverse of the QPP index generator: accepts one interleaved soft-bit block of length K and emits the same samples in natural order.
- Input sample i is written to buffer address pi(i) = (f1*i + f2*i^2) mod K. The buffer is then read out sequentially from 0 to K-1.
- Sits on the decoder side of the turbo chain, after the interleaved-parity path and before the natural-order consumer.
- Index sequence is generated internally by the same recursion used on the interleaver side.

---
 rtl/qpp_deinterleaver.sv | 211 +++++++++++++++++++++
 tb/tb_qpp_deinterleaver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qpp_deinterleaver.sv
// qpp_deinterleaver
//   Collects one interleaved soft-bit block of length K and replays it in
//   natural order. Input sample i lands at buffer address
//   pi(i) = (f1*i + f2*i^2) mod K. The address sequence comes from the
//   usual second-order recursion (pi += g, g += 2*f2). The buffer is then
//   drained through a two-register read pipeline (RAM read, output register).
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   start          one-cycle request in IDLE; latches f1, f2, K
//   f1, f2, K      QPP coefficients (< K) and block length (1..DEPTH-1)
//   in_data/in_valid/in_ready      interleaved sample stream
//   out_data/out_valid/out_ready   natural-order sample stream
//   out_last       flags sample K-1 (qualified by out_valid)
//   busy           any state other than IDLE
//   done           one-cycle pulse after the final output handshake
//   err            one-cycle pulse when start arrives with K == 0
module qpp_deinterleaver #(
  parameter int DATA_W = 8,
  parameter int F_W    = 8,
  parameter int K_W    = 8,
  parameter int DEPTH  = 2**K_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [F_W-1:0]           f1,
  input  logic [F_W-1:0]           f2,
  input  logic [K_W-1:0]           K,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int A_W = K_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOAD, S_DRAIN} state_t;

  // Operands are always < 2K, so one conditional subtract is a full mod K.
  function automatic logic [K_W-1:0] mod_once(input logic [A_W-1:0] x,
                                              input logic [K_W-1:0] k);
    logic [A_W-1:0] kk;
    kk = A_W'(k);
    mod_once = (x >= kk) ? K_W'(x - kk) : K_W'(x);
  endfunction

  state_t                   state_q, state_d;
  logic [F_W-1:0]           f1_q, f1_d, f2_q, f2_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [K_W-1:0]           g_q, g_d, s2_q, s2_d, pi_q, pi_d;
  logic [K_W-1:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                     rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                     in_ready_q, in_ready_d, busy_q, busy_d;
  logic                     done_q, done_d, err_q, err_d;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_data_q;

  logic wr_fire, adv, rd_issue, last_fire;

  assign wr_fire   = (state_q == S_LOAD) && in_valid && in_ready_q;
  // The whole read pipeline moves only when the output register frees up,
  // so a stall freezes both stages and nothing is dropped or repeated.
  assign adv       = !out_valid_q || out_ready;
  assign rd_issue  = (state_q == S_DRAIN) && adv && (rd_cnt_q < k_q);
  assign last_fire = out_valid_q && out_ready && out_last_q;

  always_comb begin
    state_d     = state_q;
    f1_d        = f1_q;
    f2_d        = f2_q;
    k_d         = k_q;
    g_d         = g_q;
    s2_d        = s2_q;
    pi_d        = pi_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_vld_d    = rd_vld_q;
    rd_last_d   = rd_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (K != '0) begin
            f1_d    = f1;
            f2_d    = f2;
            k_d     = K;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        g_d        = mod_once(A_W'(f1_q) + A_W'(f2_q), k_q);
        s2_d       = mod_once(A_W'(f2_q) << 1, k_q);
        pi_d       = '0;
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        rd_vld_d   = 1'b0;
        rd_last_d  = 1'b0;
        in_ready_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (wr_fire) begin
          pi_d     = mod_once(A_W'(pi_q) + A_W'(g_q), k_q);
          g_d      = mod_once(A_W'(g_q) + A_W'(s2_q), k_q);
          wr_cnt_d = wr_cnt_q + K_W'(1);
          if (wr_cnt_q == k_q - K_W'(1)) begin
            in_ready_d = 1'b0;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // stage p1: RAM read register -> stage p2: output register
        if (adv) begin
          out_valid_d = rd_vld_q;
          out_last_d  = rd_last_q;
          if (rd_vld_q) out_data_d = rd_data_q;
          rd_vld_d    = rd_issue;
          rd_last_d   = rd_issue && (rd_cnt_q == k_q - K_W'(1));
          if (rd_issue) rd_cnt_d = rd_cnt_q + K_W'(1);
        end
        if (last_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rd_vld_d    = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      f1_q        <= '0;
      f2_q        <= '0;
      k_q         <= '0;
      g_q         <= '0;
      s2_q        <= '0;
      pi_q        <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      k_q         <= k_d;
      g_q         <= g_d;
      s2_q        <= s2_d;
      pi_q        <= pi_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Buffer keeps its contents through reset; read has one cycle of latency.
  always_ff @(posedge clk) begin
    if (wr_fire)  mem[pi_q]   <= in_data;
    if (rd_issue) rd_data_q   <= mem[rd_cnt_q];
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_qpp_deinterleaver.sv
module tb_qpp_deinterleaver;
  localparam int DATA_W = 8;
  localparam int F_W    = 8;
  localparam int K_W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [F_W-1:0]    f1 = '0;
  logic [F_W-1:0]    f2 = '0;
  logic [K_W-1:0]    K = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qpp_deinterleaver #(.DATA_W(DATA_W), .F_W(F_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .f1(f1), .f2(f2), .K(K),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int k; int f1; int f2; bit gap; bit stall; bit sil; int pos; int val;
  } vec_t;
  vec_t vecs[7];

  logic [7:0] got[256];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // mode 0: in_data = i, mode 1: random data, mode 2: constant 0xA5
  task automatic run_block(input int k, input int f1v, input int f2v,
                           input bit gap, input bit stall, input int mode,
                           input bit sil);
    logic [7:0] din[256];
    logic [7:0] exp_v[256];
    int sent, recv, hs_edge, budget, addr;
    bit err_seen, held, hv_last, seen_v, sil_done;
    logic [7:0] hv_data;
    for (int i = 0; i < k; i++)
      din[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom) : 8'hA5;
    // Reference: sample i belongs at natural position pi(i).
    for (int i = 0; i < k; i++) begin
      addr = int'((longint'(f1v) * longint'(i) + longint'(f2v) * longint'(i) * longint'(i))
                  % longint'(k));
      exp_v[addr] = din[i];
    end
    start = 1'b1; K = K_W'(k); f1 = F_W'(f1v); f2 = F_W'(f2v);
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("done_one_cycle", int'(done), 0);

    sent = 0; budget = 0; err_seen = 0; hs_edge = 0; sil_done = 0;
    while (sent < k && budget < 8 * k + 50) begin
      in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = din[sent];
      if (sil && sent == 2 && !sil_done) begin
        start = 1'b1; K = '0; sil_done = 1;
      end
      @(negedge clk);
      if (err) err_seen = 1;
      if (in_valid && in_ready) begin
        sent++;
        hs_edge = cyc + 1;
      end
      budget++;
      @(posedge clk); #1;
      start = 1'b0; K = K_W'(k);
    end
    in_valid = 1'b0;
    chk("inputs_accepted", sent, k);

    recv = 0; budget = 0; held = 0; seen_v = 0; hv_last = 0; hv_data = '0;
    while (recv < k && budget < 8 * k + 50) begin
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (err) err_seen = 1;
      if (budget == 0) chk("in_ready_low_drain", int'(in_ready), 0);
      if (out_valid && !seen_v) begin
        seen_v = 1;
        chk("first_out_latency", cyc - hs_edge, 2);
      end
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(hv_data));
        chk("hold_last", int'(out_last), int'(hv_last));
      end
      held = out_valid && !out_ready;
      hv_data = out_data;
      hv_last = out_last;
      if (out_valid && out_ready) begin
        chk("out_data", int'(out_data), int'(exp_v[recv]));
        chk("out_last", int'(out_last), int'(recv == k - 1));
        got[recv] = out_data;
        recv++;
      end
      budget++;
      @(posedge clk); #1;
    end
    chk("outputs_seen", recv, k);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("valid_after_done", int'(out_valid), 0);
    chk("no_err", int'(err_seen), 0);
  endtask

  initial begin
    int n, idx;
    vecs[0] = '{k: 8,   f1: 3,  f2: 4,  gap: 0, stall: 0, sil: 0, pos: 1,  val: 7};
    vecs[1] = '{k: 8,   f1: 3,  f2: 4,  gap: 1, stall: 1, sil: 0, pos: 7,  val: 1};
    vecs[2] = '{k: 40,  f1: 3,  f2: 10, gap: 0, stall: 0, sil: 1, pos: 6,  val: 2};
    vecs[3] = '{k: 40,  f1: 3,  f2: 10, gap: 1, stall: 1, sil: 0, pos: 19, val: 3};
    vecs[4] = '{k: 16,  f1: 1,  f2: 4,  gap: 0, stall: 1, sil: 0, pos: 5,  val: 1};
    vecs[5] = '{k: 48,  f1: 7,  f2: 12, gap: 1, stall: 0, sil: 0, pos: 19, val: 1};
    vecs[6] = '{k: 200, f1: 13, f2: 50, gap: 1, stall: 1, sil: 0, pos: 63, val: 1};

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // start with K == 0
    start = 1'b1; K = '0;
    @(posedge clk); #1 start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("err_clears", int'(err), 0);
    @(negedge clk);

    // Table-driven blocks, data = index
    for (int r = 0; r < 7; r++) begin
      run_block(vecs[r].k, vecs[r].f1, vecs[r].f2, vecs[r].gap, vecs[r].stall, 0, vecs[r].sil);
      chk("spot_value", int'(got[vecs[r].pos]), vecs[r].val);
    end

    // K == 1
    run_block(1, 0, 0, 0, 0, 2, 0);
    chk("k1_data", int'(got[0]), 8'hA5);

    // Reset in the middle of LOAD, then a clean block
    start = 1'b1; K = 8'd8; f1 = 8'd3; f2 = 8'd4;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int b = 0; b < 20 && n < 3; b++) begin
      in_valid = 1'b1; in_data = 8'(n + 100);
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("midload_samples", n, 3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    run_block(8, 3, 4, 0, 0, 0, 0);
    chk("post_rst_spot", int'(got[1]), 7);

    // Randomized blocks against the reference model
    for (int t = 0; t < 4; t++) begin
      idx = $urandom_range(0, 6);
      run_block(vecs[idx].k, vecs[idx].f1, vecs[idx].f2, 1, 1, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
